operand_assembler: RTL and testbench

OPERAND_ASSEMBLER -- requirements
Module: operand_assembler

---
 rtl/operand_assembler.sv | 194 +++++++++++++++++++
 tb/tb_operand_assembler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_assembler.sv
// operand_assembler: turns calculator keypad tokens into two signed
// operands and an operator, then hands them to the ALU by request/ack.
// Ports:
//   clk, RST (async, active high)
//   read_input/key_read      token valid / one-cycle acknowledge
//   keypad_input[3:0]        decimal digit
//   operator_input[2:0]      001 sign, 010 add, 011 sub, 100 mul, 110 clear
//   equal_input              equal key
//   operand_a/b[15:0]        latched signed operands
//   alu_op[2:0]              latched operator
//   calc_req/calc_ack        ALU request handshake
//   display_value[15:0]      signed entry in progress
//   overflow                 sticky entry overflow
// Optional: define CLEAR_KEY_EN to make op 110 a full clear.
module operand_assembler (
   input  logic        clk,
   input  logic        RST,
   input  logic        read_input,
   output logic        key_read,
   input  logic [3:0]  keypad_input,
   input  logic [2:0]  operator_input,
   input  logic        equal_input,
   output logic [15:0] operand_a,
   output logic [15:0] operand_b,
   output logic [2:0]  alu_op,
   output logic        calc_req,
   input  logic        calc_ack,
   output logic [15:0] display_value,
   output logic        overflow
);

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      REQ     = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        armed_q, armed_d;
   logic        kr_q, kr_d;
   logic [14:0] mag_q, mag_d;
   logic        sign_q, sign_d;
   logic        ovf_q, ovf_d;
   logic        dig_q, dig_d;
   logic [15:0] opa_q, opa_d;
   logic [15:0] opb_q, opb_d;
   logic [2:0]  op_q, op_d;
   logic        req_q, req_d;

   logic        accept;
   logic        is_op, is_eq, is_dig;
   logic        is_sign, is_arith, is_clr;
   logic [15:0] entry_val;
   logic [18:0] prod;

   // Token class: operator beats equal beats digit.
   assign is_op    = (operator_input != 3'b000);
   assign is_eq    = !is_op && equal_input;
   assign is_dig   = !is_op && !equal_input;
   assign is_sign  = (operator_input == 3'b001);
   assign is_arith = (operator_input == 3'b010) ||
                     (operator_input == 3'b011) ||
                     (operator_input == 3'b100);
   assign is_clr   = (operator_input == 3'b110);

   assign accept = read_input && armed_q && (state_q != REQ);

   assign entry_val = sign_q ? (16'd0 - {1'b0, mag_q})
                             : {1'b0, mag_q};

   // Max 32767*10+9 fits in 19 bits, so no wrap before the range test.
   assign prod = ({4'd0, mag_q} * 19'd10) + {15'd0, keypad_input};

   always_comb begin
      state_d = state_q;
      kr_d    = 1'b0;
      mag_d   = mag_q;
      sign_d  = sign_q;
      ovf_d   = ovf_q;
      dig_d   = dig_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      op_d    = op_q;
      req_d   = req_q;

      // One accept per press: re-arm only once the key is released.
      if (accept) begin
         armed_d = 1'b0;
      end else if (!read_input) begin
         armed_d = 1'b1;
      end else begin
         armed_d = armed_q;
      end

      if (accept) begin
         kr_d = 1'b1;
         unique case (1'b1)
            is_op: begin
               if (is_sign) begin
                  sign_d = !sign_q;
               end else if (is_arith) begin
                  if (state_q == ENTER_A) begin
                     opa_d   = entry_val;
                     op_d    = operator_input;
                     mag_d   = '0;
                     sign_d  = 1'b0;
                     dig_d   = 1'b0;
                     state_d = ENTER_B;
                  end else if (!dig_q) begin
                     op_d = operator_input;
                  end
               end else if (is_clr) begin
`ifdef CLEAR_KEY_EN
                  mag_d   = '0;
                  sign_d  = 1'b0;
                  ovf_d   = 1'b0;
                  dig_d   = 1'b0;
                  opa_d   = '0;
                  opb_d   = '0;
                  op_d    = '0;
                  state_d = ENTER_A;
`else
                  op_d = op_q;
`endif
               end
            end
            is_eq: begin
               if (state_q == ENTER_B && dig_q) begin
                  opb_d   = entry_val;
                  req_d   = 1'b1;
                  state_d = REQ;
               end
            end
            is_dig: begin
               dig_d = 1'b1;
               if (prod > 19'd32767) begin
                  ovf_d = 1'b1;
               end else begin
                  mag_d = prod[14:0];
               end
            end
            default: begin
               kr_d = 1'b1;
            end
         endcase
      end

      if (state_q == REQ && calc_ack) begin
         req_d   = 1'b0;
         mag_d   = '0;
         sign_d  = 1'b0;
         ovf_d   = 1'b0;
         dig_d   = 1'b0;
         state_d = ENTER_A;
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q <= ENTER_A;
         armed_q <= 1'b1;
         kr_q    <= 1'b0;
         mag_q   <= '0;
         sign_q  <= 1'b0;
         ovf_q   <= 1'b0;
         dig_q   <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         op_q    <= '0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         kr_q    <= kr_d;
         mag_q   <= mag_d;
         sign_q  <= sign_d;
         ovf_q   <= ovf_d;
         dig_q   <= dig_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         op_q    <= op_d;
         req_q   <= req_d;
      end
   end

   assign key_read      = kr_q;
   assign operand_a     = opa_q;
   assign operand_b     = opb_q;
   assign alu_op        = op_q;
   assign calc_req      = req_q;
   assign display_value = entry_val;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_operand_assembler.sv
// tb_operand_assembler: directed token sequences with hand-computed
// expectations, checked by a scoreboard monitor on each key_read pulse.
module tb_operand_assembler;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic        read_input = 1'b0;
   logic        key_read;
   logic [3:0]  keypad_input = '0;
   logic [2:0]  operator_input = '0;
   logic        equal_input = 1'b0;
   logic [15:0] operand_a, operand_b, display_value;
   logic [2:0]  alu_op;
   logic        calc_req;
   logic        calc_ack = 1'b0;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   int kr_cnt = 0;

   typedef struct packed {
      logic [15:0] disp;
      logic        ovf;
      logic [15:0] opa;
      logic [15:0] opb;
      logic [2:0]  op;
      logic        req;
   } exp_t;

   exp_t sb[$];

   operand_assembler dut (
      .clk(clk), .RST(RST),
      .read_input(read_input), .key_read(key_read),
      .keypad_input(keypad_input),
      .operator_input(operator_input),
      .equal_input(equal_input),
      .operand_a(operand_a), .operand_b(operand_b),
      .alu_op(alu_op), .calc_req(calc_req), .calc_ack(calc_ack),
      .display_value(display_value), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic exp_t e(input logic [15:0] d, input logic v,
                              input logic [15:0] a,
                              input logic [15:0] b,
                              input logic [2:0] o, input logic r);
      exp_t x;
      x.disp = d; x.ovf = v; x.opa = a;
      x.opb = b; x.op = o; x.req = r;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Monitor: each key_read pulse pops one expectation.
   always @(negedge clk) begin
      if (!RST && key_read === 1'b1) begin
         exp_t x;
         kr_cnt++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key_read actual=1 required=0");
         end else begin
            x = sb.pop_front();
            chk("display_value", display_value, x.disp);
            chk("overflow", {15'd0, overflow}, {15'd0, x.ovf});
            chk("operand_a", operand_a, x.opa);
            chk("operand_b", operand_b, x.opb);
            chk("alu_op", {13'd0, alu_op}, {13'd0, x.op});
            chk("calc_req", {15'd0, calc_req}, {15'd0, x.req});
         end
      end
   end

   task automatic tok(input logic [3:0] d, input logic [2:0] o,
                      input logic q, input exp_t x);
      int n;
      sb.push_back(x);
      @(negedge clk);
      keypad_input = d; operator_input = o; equal_input = q;
      read_input = 1'b1;
      n = 0;
      @(negedge clk);
      while (key_read !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL key_read_timeout actual=0 required=1");
         void'(sb.pop_front());
      end
      @(negedge clk);
      read_input = 1'b0;
      operator_input = '0; equal_input = 1'b0;
      @(negedge clk);
   endtask

   task automatic dig(input logic [3:0] d, input exp_t x);
      tok(d, 3'b000, 1'b0, x);
   endtask

   task automatic ack_cycle;
      @(negedge clk);
      calc_ack = 1'b1;
      @(posedge clk);
      #1;
      chk("calc_req_after_ack", {15'd0, calc_req}, 16'd0);
      chk("display_after_ack", display_value, 16'd0);
      @(negedge clk);
      calc_ack = 1'b0;
   endtask

   initial begin
      int c0;
      #1;
      chk("rst_display", display_value, 16'd0);
      chk("rst_opa", operand_a, 16'd0);
      chk("rst_req", {15'd0, calc_req}, 16'd0);
      #20;
      @(negedge clk);
      RST = 1'b0;

      // 123 add 45 equal
      dig(4'd1, e(16'd1, 0, 0, 0, 0, 0));
      dig(4'd2, e(16'd12, 0, 0, 0, 0, 0));
      dig(4'd3, e(16'h7B, 0, 0, 0, 0, 0));
      tok(0, 3'b010, 0, e(0, 0, 16'h7B, 0, 3'b010, 0));
      dig(4'd4, e(16'd4, 0, 16'h7B, 0, 3'b010, 0));
      dig(4'd5, e(16'h2D, 0, 16'h7B, 0, 3'b010, 0));
      tok(0, 3'b000, 1, e(16'h2D, 0, 16'h7B, 16'h2D, 3'b010, 1));
      repeat (3) @(negedge clk);
      chk("calc_req_hold", {15'd0, calc_req}, 16'd1);
      ack_cycle();
      chk("opa_hold", operand_a, 16'h7B);
      chk("opb_hold", operand_b, 16'h2D);

      // -5 sub -7, operator replace and discards in ENTER_B
      dig(4'd5, e(16'd5, 0, 16'h7B, 16'h2D, 3'b010, 0));
      tok(0, 3'b001, 0, e(16'hFFFB, 0, 16'h7B, 16'h2D, 3'b010, 0));
      tok(0, 3'b010, 0, e(0, 0, 16'hFFFB, 16'h2D, 3'b010, 0));
      tok(0, 3'b011, 0, e(0, 0, 16'hFFFB, 16'h2D, 3'b011, 0));
      tok(0, 3'b000, 1, e(0, 0, 16'hFFFB, 16'h2D, 3'b011, 0));
      dig(4'd7, e(16'd7, 0, 16'hFFFB, 16'h2D, 3'b011, 0));
      tok(0, 3'b100, 0, e(16'd7, 0, 16'hFFFB, 16'h2D, 3'b011, 0));
      tok(0, 3'b001, 0, e(16'hFFF9, 0, 16'hFFFB, 16'h2D, 3'b011, 0));
      tok(0, 3'b000, 1,
          e(16'hFFF9, 0, 16'hFFFB, 16'hFFF9, 3'b011, 1));

      // Token pending in REQ is held off until after the ack
      c0 = kr_cnt;
      @(negedge clk);
      keypad_input = 4'd9; read_input = 1'b1;
      repeat (4) @(negedge clk);
      chk("no_accept_in_req", 16'(kr_cnt - c0), 16'd0);
      sb.push_back(e(16'd9, 0, 16'hFFFB, 16'hFFF9, 3'b011, 0));
      ack_cycle();
      repeat (3) @(negedge clk);
      read_input = 1'b0;
      @(negedge clk);
      chk("accept_after_ack", 16'(kr_cnt - c0), 16'd1);

      // Equal in ENTER_A and unused op 101 are discarded
      tok(0, 3'b000, 1, e(16'd9, 0, 16'hFFFB, 16'hFFF9, 3'b011, 0));
      tok(0, 3'b101, 0, e(16'd9, 0, 16'hFFFB, 16'hFFF9, 3'b011, 0));

      // Held key: exactly one accept over 10 cycles
      c0 = kr_cnt;
      sb.push_back(e(16'h5B, 0, 16'hFFFB, 16'hFFF9, 3'b011, 0));
      @(negedge clk);
      keypad_input = 4'd1; read_input = 1'b1;
      repeat (10) @(negedge clk);
      read_input = 1'b0;
      @(negedge clk);
      chk("held_one_pulse", 16'(kr_cnt - c0), 16'd1);
      dig(4'd2, e(16'h390, 0, 16'hFFFB, 16'hFFF9, 3'b011, 0));

      // Asynchronous reset mid-entry
      @(negedge clk);
      #2;
      RST = 1'b1;
      #1;
      chk("arst_display", display_value, 16'd0);
      chk("arst_opa", operand_a, 16'd0);
      chk("arst_opb", operand_b, 16'd0);
      chk("arst_op", {13'd0, alu_op}, 16'd0);
      @(negedge clk);
      RST = 1'b0;

      // Magnitude overflow
      dig(4'd3, e(16'd3, 0, 0, 0, 0, 0));
      dig(4'd2, e(16'd32, 0, 0, 0, 0, 0));
      dig(4'd7, e(16'd327, 0, 0, 0, 0, 0));
      dig(4'd6, e(16'd3276, 0, 0, 0, 0, 0));
      dig(4'd7, e(16'h7FFF, 0, 0, 0, 0, 0));
      dig(4'd8, e(16'h7FFF, 1, 0, 0, 0, 0));

      // Clear key in ENTER_B
      tok(0, 3'b010, 0, e(0, 1, 16'h7FFF, 0, 3'b010, 0));
      dig(4'd4, e(16'd4, 1, 16'h7FFF, 0, 3'b010, 0));
`ifdef CLEAR_KEY_EN
      tok(0, 3'b110, 0, e(0, 0, 0, 0, 0, 0));
      tok(0, 3'b000, 1, e(0, 0, 0, 0, 0, 0));
`else
      tok(0, 3'b110, 0, e(16'd4, 1, 16'h7FFF, 0, 3'b010, 0));
      tok(0, 3'b000, 1, e(16'd4, 1, 16'h7FFF, 16'd4, 3'b010, 1));
      @(negedge clk);
      calc_ack = 1'b1;
      @(posedge clk);
      #1;
      chk("ovf_clr_on_ack", {15'd0, overflow}, 16'd0);
      chk("req_clr_on_ack", {15'd0, calc_req}, 16'd0);
      @(negedge clk);
      calc_ack = 1'b0;
`endif

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 16'(sb.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
